// File: rtl/dds_key_ctrl_if.sv
// Key-pulse inputs and DDS outputs of dds_key_ctrl.
// The key_down signal exists only when KEY_DOWN_EN is defined.
interface dds_key_ctrl_if #(
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned ADDR_W = 10
);
  logic              key_freq;
  logic              key_wave;
`ifdef KEY_DOWN_EN
  logic              key_down;
`endif
  logic [ACC_W-1:0]  fword;
  logic [1:0]        wave_sel;
  logic [ADDR_W-1:0] rom_addr;
  logic              upd;

`ifdef KEY_DOWN_EN
  modport master (output key_freq, key_wave, key_down, input fword, wave_sel, rom_addr, upd);
  modport slave  (input key_freq, key_wave, key_down, output fword, wave_sel, rom_addr, upd);
`else
  modport master (output key_freq, key_wave, input fword, wave_sel, rom_addr, upd);
  modport slave  (input key_freq, key_wave, output fword, wave_sel, rom_addr, upd);
`endif
endinterface

// File: rtl/dds_key_ctrl.sv
// Key-driven DDS controller: frequency preset / waveform select FSM, phase accumulator, ROM address.
// Optional macro KEY_DOWN_EN adds a key_down input that steps the frequency preset down.
module dds_key_ctrl #(
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned ADDR_W = 10
) (
  input  logic          sclk,
  input  logic          rst_n,
  dds_key_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, STEP = 2'd1, LOAD = 2'd2} state_e;

  localparam logic [ACC_W-1:0] FWORD_RST = ACC_W'(32'd85899);

  function automatic logic [ACC_W-1:0] preset(input logic [2:0] i);
    logic [31:0] w;
    case (i)
      3'd0:    w = 32'd85899;
      3'd1:    w = 32'd858993;
      3'd2:    w = 32'd4294967;
      3'd3:    w = 32'd8589934;
      3'd4:    w = 32'd42949672;
      3'd5:    w = 32'd85899345;
      3'd6:    w = 32'd171798691;
      default: w = 32'd429496729;
    endcase
    return ACC_W'(w);
  endfunction

  state_e            state_q, state_d;
  logic              kf_q, kf_d, kw_q, kw_d, kd_q, kd_d;
  logic              rq_up_q, rq_up_d, rq_wave_q, rq_wave_d, rq_dn_q, rq_dn_d;
  logic [2:0]        idx_q, idx_d;
  logic [1:0]        wave_sel_q, wave_sel_d;
  logic [ACC_W-1:0]  fword_q, fword_d;
  logic              upd_q, upd_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              any_key;

  // Keys pass through one register stage before the FSM sees them,
  // which places STEP one edge after the sampling edge.
  assign kf_d = bus.key_freq;
  assign kw_d = bus.key_wave;
`ifdef KEY_DOWN_EN
  assign kd_d = bus.key_down;
`else
  assign kd_d = 1'b0;
`endif
  assign any_key = kf_q | kw_q | kd_q;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_key) state_d = STEP;
      STEP:    state_d = LOAD;
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rq_up_d    = rq_up_q;
    rq_wave_d  = rq_wave_q;
    rq_dn_d    = rq_dn_q;
    idx_d      = idx_q;
    wave_sel_d = wave_sel_q;
    fword_d    = fword_q;
    upd_d      = 1'b0;
    acc_d      = acc_q + fword_q;
    rom_addr_d = acc_q[ACC_W-1 -: ADDR_W];
    case (state_q)
      IDLE: begin
        if (any_key) begin
          rq_up_d   = kf_q;
          rq_wave_d = kw_q;
          rq_dn_d   = kd_q;
        end
      end
      STEP: begin
        // Simultaneous up and down requests cancel.
        if (rq_up_q && !rq_dn_q)      idx_d = idx_q + 3'd1;
        else if (rq_dn_q && !rq_up_q) idx_d = idx_q - 3'd1;
        if (rq_wave_q) wave_sel_d = wave_sel_q + 2'd1;
      end
      LOAD: begin
        fword_d = preset(idx_q);
        upd_d   = rq_wave_q | (rq_up_q ^ rq_dn_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      kf_q       <= 1'b0;
      kw_q       <= 1'b0;
      kd_q       <= 1'b0;
      rq_up_q    <= 1'b0;
      rq_wave_q  <= 1'b0;
      rq_dn_q    <= 1'b0;
      idx_q      <= '0;
      wave_sel_q <= '0;
      fword_q    <= FWORD_RST;
      upd_q      <= 1'b0;
      acc_q      <= '0;
      rom_addr_q <= '0;
    end else begin
      kf_q       <= kf_d;
      kw_q       <= kw_d;
      kd_q       <= kd_d;
      rq_up_q    <= rq_up_d;
      rq_wave_q  <= rq_wave_d;
      rq_dn_q    <= rq_dn_d;
      idx_q      <= idx_d;
      wave_sel_q <= wave_sel_d;
      fword_q    <= fword_d;
      upd_q      <= upd_d;
      acc_q      <= acc_d;
      rom_addr_q <= rom_addr_d;
    end
  end

  assign bus.fword    = fword_q;
  assign bus.wave_sel = wave_sel_q;
  assign bus.rom_addr = rom_addr_q;
  assign bus.upd      = upd_q;
endmodule

// File: tb/tb_dds_key_ctrl.sv
// Directed bench for dds_key_ctrl: vector table of key pulses plus hand sequences
// for accumulator wrap, dropped pulses and reset during STEP.
`timescale 1ns/1ps
module tb_dds_key_ctrl;
  logic sclk  = 1'b0;
  logic rst_n = 1'b0;
  int   n_run  = 0;
  int   n_fail = 0;

  dds_key_ctrl_if #(.ACC_W(32), .ADDR_W(10)) bus ();

  dds_key_ctrl #(.ACC_W(32), .ADDR_W(10)) dut (
    .sclk  (sclk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 sclk = ~sclk;

  typedef struct {
    logic        kf;
    logic        kw;
    logic        kd;
    logic        exp_upd;
    logic [31:0] exp_fword;
    logic [1:0]  exp_wave;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic set_keys(input logic kf, input logic kw, input logic kd);
    bus.key_freq = kf;
    bus.key_wave = kw;
`ifdef KEY_DOWN_EN
    bus.key_down = kd;
`else
    if (kd) $display("note: key_down ignored in this build");
`endif
  endtask

  task automatic do_reset();
    @(negedge sclk);
    set_keys(1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge sclk);
    rst_n = 1'b1;
  endtask

  // Pulse at edge N, expect quiet upd at N+1/N+2, result at N+3, upd low again at N+4.
  task automatic apply_vec(input int i, input vec_t v);
    logic [1:0] early;
    set_keys(v.kf, v.kw, v.kd);
    tick();
    set_keys(1'b0, 1'b0, 1'b0);
    tick(); early[0] = bus.upd;
    tick(); early[1] = bus.upd;
    check($sformatf("v%0d_upd_early", i), early, 0);
    tick();
    check($sformatf("v%0d_upd", i), bus.upd, v.exp_upd);
    check($sformatf("v%0d_fword", i), bus.fword, v.exp_fword);
    check($sformatf("v%0d_wave", i), bus.wave_sel, v.exp_wave);
    tick();
    check($sformatf("v%0d_upd_single", i), bus.upd, 0);
    repeat (2) tick();
  endtask

  function automatic logic [31:0] model_acc(input int unsigned k);
    logic [63:0] p;
    p = 64'(k) * 64'd85899;
    return p[31:0];
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    int          upd_cnt;
    vec_t        v;

    set_keys(1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #12;
    check("rst_fword", bus.fword, 85899);
    check("rst_wave", bus.wave_sel, 0);
    check("rst_upd", bus.upd, 0);
    check("rst_rom_addr", bus.rom_addr, 0);
    check("rst_acc", dut.acc_q, 0);
    @(negedge sclk);
    rst_n = 1'b1;

    // Accumulator from reset with the default tuning word.
    tick();
    check("first_fword", bus.fword, 85899);
    check("first_upd", bus.upd, 0);
    check("first_rom_addr", bus.rom_addr, 0);
    check("first_acc", dut.acc_q, 85899);
    for (int unsigned k = 2; k <= 50002; k++) begin
      tick();
      if (k == 1000) begin
        a = model_acc(k - 1);
        check("acc_1000", dut.acc_q, model_acc(k));
        check("rom_1000", bus.rom_addr, a[31:22]);
      end
      if (k == 50000) check("acc_50000", dut.acc_q, 32'd4294950000);
      if (k == 50001) begin
        check("acc_wrap", dut.acc_q, 68603);
        check("rom_1023", bus.rom_addr, 1023);
      end
      if (k == 50002) check("rom_wrap", bus.rom_addr, 0);
    end

    // Table of single-event pulses from a fresh reset.
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 32'd858993,    2'd0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 32'd4294967,   2'd0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 32'd8589934,   2'd0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 32'd42949672,  2'd0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 32'd85899345,  2'd0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 32'd171798691, 2'd0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 32'd429496729, 2'd0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 32'd85899,     2'd0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 32'd85899,     2'd1});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 32'd85899,     2'd2});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 32'd85899,     2'd3});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 32'd85899,     2'd0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 32'd858993,    2'd1});
`ifdef KEY_DOWN_EN
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 32'd85899,     2'd1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 32'd429496729, 2'd1});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 32'd429496729, 2'd1});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 32'd429496729, 2'd2});
`endif
    do_reset();
    for (int i = 0; i < vecs.size(); i++) apply_vec(i, vecs[i]);

    // Both keys together, then key_freq again while the FSM is in STEP.
    do_reset();
    set_keys(1'b1, 1'b1, 1'b0);
    tick();
    set_keys(1'b1, 1'b0, 1'b0);
    tick();
    set_keys(1'b0, 1'b0, 1'b0);
    tick();
    check("drop_upd_early", bus.upd, 0);
    tick();
    check("drop_upd", bus.upd, 1);
    check("drop_fword", bus.fword, 858993);
    check("drop_wave", bus.wave_sel, 1);
    upd_cnt = 0;
    repeat (10) begin
      tick();
      if (bus.upd) upd_cnt++;
    end
    check("drop_no_second_upd", upd_cnt, 0);
    check("drop_fword_hold", bus.fword, 858993);

    // Reset asserted while the FSM is in STEP abandons the request.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      v = vecs[i];
      apply_vec(100 + i, v);
    end
    set_keys(1'b1, 1'b0, 1'b0);
    tick();
    set_keys(1'b0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_fword", bus.fword, 85899);
    check("midrst_wave", bus.wave_sel, 0);
    check("midrst_upd", bus.upd, 0);
    check("midrst_rom_addr", bus.rom_addr, 0);
    @(negedge sclk);
    rst_n = 1'b1;
    upd_cnt = 0;
    repeat (6) begin
      tick();
      if (bus.upd) upd_cnt++;
    end
    check("midrst_no_upd", upd_cnt, 0);
    check("midrst_fword_hold", bus.fword, 85899);
    v = '{1'b1, 1'b0, 1'b0, 1'b1, 32'd858993, 2'd0};
    apply_vec(200, v);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
